pb_load_ctrl: RTL and testbench

PB_LOAD_CTRL -- requirements
Module: pb_load_ctrl

---
 rtl/pb_load_ctrl_pkg.sv | 40 ++++
 rtl/pb_load_ctrl_sync.sv | 40 ++++
 rtl/pb_load_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pb_load_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_load_ctrl_pkg.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Package : pb_pack                                                          |
// | Purpose : Shared widths, state encoding and default timing constants for   |
// |           the program-buffer load controller.                              |
// | Contents: globalAddress_width, data_width, LOAD_TIMEOUT_DEFAULT,           |
// |           RELEASE_CYCLES_DEFAULT, pb_load_state_t, sat_inc16()             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package pb_pack;

  // Memory bus geometry shared by the JTAG loader and the CPU store path.
  localparam int globalAddress_width = 16;
  localparam int data_width          = 32;

  // Default load/release timing in core clock cycles.
  localparam int LOAD_TIMEOUT_DEFAULT   = 1024;
  localparam int RELEASE_CYCLES_DEFAULT = 16;

  // Loader state; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    PB_IDLE    = 2'd0,
    PB_LOAD    = 2'd1,
    PB_RELEASE = 2'd2
  } pb_load_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end
    return value + 16'd1;
  endfunction

endpackage : pb_pack

`default_nettype wire

// File: rtl/pb_load_ctrl_sync.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module  : pb_sync                                                          |
// | Purpose : N-flop single-bit synchronizer with synchronous reset.           |
// | Ports   : clk_i  - destination clock                                       |
// |           rst_i  - synchronous active-high reset (clears every stage)      |
// |           d_i    - asynchronous input bit                                  |
// |           q_o    - synchronized output (last stage)                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module pb_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  // Fewer than two stages gives no metastability protection, so clamp.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] r_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N-2:0], d_i};
    end
  end

  assign q_o = r_sync[N-1];

endmodule : pb_sync

`default_nettype wire

// File: rtl/pb_load_ctrl.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module  : pb_load_ctrl                                                     |
// | Purpose : Arbitrates a shared program memory between JTAG loading and the |
// |           CPU store path, and holds the CPU in reset while a load is in   |
// |           progress and for a short release window afterwards.            |
// | Ports   : clk_i, rst_i            - core clock, sync active-high reset    |
// |           jtag_wen_i/addr/data    - JTAG write strobe level (TCK domain)  |
// |                                     with address/data held stable         |
// |           cpu_we_i/addr/wdata     - CPU store request                     |
// |           mem_we_o/addr/wdata     - shared memory write port              |
// |           cpu_rst_o               - registered CPU reset                  |
// |           loading_o               - high while in LOAD                    |
// |           load_done_o             - one-cycle pulse on RELEASE -> IDLE    |
// |           load_count_o            - JTAG words written in current load    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module pb_load_ctrl
  import pb_pack::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LOAD_TIMEOUT   = LOAD_TIMEOUT_DEFAULT,
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           jtag_wen_i,
  input  logic [globalAddress_width-1:0] jtag_addr_i,
  input  logic [data_width-1:0]          jtag_data_i,
  input  logic                           cpu_we_i,
  input  logic [globalAddress_width-1:0] cpu_addr_i,
  input  logic [data_width-1:0]          cpu_wdata_i,
  output logic                           mem_we_o,
  output logic [globalAddress_width-1:0] mem_addr_o,
  output logic [data_width-1:0]          mem_wdata_o,
  output logic                           cpu_rst_o,
  output logic                           loading_o,
  output logic                           load_done_o,
  output logic [15:0]                    load_count_o
);

  localparam int TO_W  = $clog2(LOAD_TIMEOUT) + 1;
  localparam int REL_W = $clog2(RELEASE_CYCLES) + 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOAD_TIMEOUT - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

  // Strobe synchronization and rising-edge detection.
  logic w_wen_sync;
  logic r_wen_prev;
  logic w_rise;

  pb_sync #(
    .STAGES (SYNC_STAGES)
  ) u_wen_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (jtag_wen_i),
    .q_o   (w_wen_sync)
  );

  // A falling edge is deliberately ignored: one JTAG write per strobe pulse.
  assign w_rise = w_wen_sync & ~r_wen_prev;

  // Controller state.
  pb_load_state_t                 r_state;
  logic [TO_W-1:0]                r_timeout;
  logic [REL_W-1:0]               r_rel_cnt;
  logic                           r_cpu_rst;
  logic                           r_loading;
  logic                           r_load_done;
  logic [15:0]                    r_load_count;
  logic                           r_pend_valid;
  logic [globalAddress_width-1:0] r_pend_addr;
  logic [data_width-1:0]          r_pend_data;
  logic                           r_mem_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= PB_RELEASE;
      r_timeout    <= '0;
      r_rel_cnt    <= '0;
      r_cpu_rst    <= 1'b1;
      r_loading    <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_count <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_mem_we     <= 1'b0;
      r_wen_prev   <= 1'b0;
    end else begin
      r_wen_prev  <= w_wen_sync;
      r_load_done <= 1'b0;
      r_mem_we    <= 1'b0;

      // Capture stage: the JTAG bus is stable while the strobe is high, so
      // sampling it once the synchronized edge appears is safe.
      if (w_rise) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= jtag_addr_i;
        r_pend_data  <= jtag_data_i;
      end else begin
        r_pend_valid <= 1'b0;
      end

      // Issue stage: pending data goes to memory one cycle after capture.
      // Strobe edges are at least two cycles apart, so capture and issue
      // never collide on the pending register.
      if (r_pend_valid) begin
        r_mem_we     <= 1'b1;
        r_load_count <= sat_inc16(r_load_count);
      end

      case (r_state)
        PB_IDLE: begin
          if (w_rise) begin
            r_state      <= PB_LOAD;
            r_timeout    <= '0;
            r_load_count <= '0;
            r_cpu_rst    <= 1'b1;
            r_loading    <= 1'b1;
          end
        end

        PB_LOAD: begin
          if (w_rise) begin
            r_timeout <= '0;
          end else if ((r_timeout == TO_LAST) && !r_pend_valid) begin
            r_state   <= PB_RELEASE;
            r_rel_cnt <= '0;
            r_loading <= 1'b0;
          end else if (r_timeout != TO_LAST) begin
            r_timeout <= r_timeout + 1'b1;
          end
        end

        PB_RELEASE: begin
          // A late write restarts the load without clearing the word count.
          if (w_rise) begin
            r_state   <= PB_LOAD;
            r_timeout <= '0;
            r_loading <= 1'b1;
          end else if (r_rel_cnt == REL_LAST) begin
            r_state     <= PB_IDLE;
            r_cpu_rst   <= 1'b0;
            r_load_done <= 1'b1;
          end else begin
            r_rel_cnt <= r_rel_cnt + 1'b1;
          end
        end

        default: begin
          r_state   <= PB_RELEASE;
          r_rel_cnt <= '0;
          r_cpu_rst <= 1'b1;
          r_loading <= 1'b0;
        end
      endcase
    end
  end

  // Memory port mux. In IDLE the CPU path is combinational, except in the
  // cycle a JTAG edge is detected: the loader takes over the next cycle and
  // the CPU write in that boundary cycle must not land.
  always_comb begin
    mem_we_o    = r_mem_we;
    mem_addr_o  = r_pend_addr;
    mem_wdata_o = r_pend_data;
    if (r_state == PB_IDLE) begin
      mem_we_o    = cpu_we_i & ~w_rise;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end
  end

  assign cpu_rst_o    = r_cpu_rst;
  assign loading_o    = r_loading;
  assign load_done_o  = r_load_done;
  assign load_count_o = r_load_count;

endmodule : pb_load_ctrl

`default_nettype wire

// File: tb/tb_pb_load_ctrl.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module  : tb_pb_load_ctrl                                                  |
// | Purpose : Directed self-checking bench for pb_load_ctrl with a write      |
// |           scoreboard on the shared memory port.                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_pb_load_ctrl;
  import pb_pack::*;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           jtag_wen;
  logic [globalAddress_width-1:0] jtag_addr;
  logic [data_width-1:0]          jtag_data;
  logic                           cpu_we;
  logic [globalAddress_width-1:0] cpu_addr;
  logic [data_width-1:0]          cpu_wdata;
  logic                           mem_we;
  logic [globalAddress_width-1:0] mem_addr;
  logic [data_width-1:0]          mem_wdata;
  logic                           cpu_rst;
  logic                           loading;
  logic                           load_done;
  logic [15:0]                    load_count;

  int n_cmp = 0;
  int n_err = 0;

  // Expected memory writes as {addr, data}.
  logic [47:0] sb[$];

  always #5 clk = ~clk;

  pb_load_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .jtag_wen_i   (jtag_wen),
    .jtag_addr_i  (jtag_addr),
    .jtag_data_i  (jtag_data),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .cpu_rst_o    (cpu_rst),
    .loading_o    (loading),
    .load_done_o  (load_done),
    .load_count_o (load_count)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every memory write is popped against the scoreboard at the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed %0h expected none", {mem_addr, mem_wdata});
      end
      if (sb.size() > 0) begin
        logic [47:0] e;
        e = sb.pop_front();
        n_cmp++;
        assert ({mem_addr, mem_wdata} === e) else begin
          n_err++;
          $error("FAIL mem_write: observed %0h expected %0h", {mem_addr, mem_wdata}, e);
        end
      end
    end
  end

  // One JTAG strobe: high 3 cycles, low 4 cycles; write issues in the 4th.
  task automatic jtag_write(input logic [15:0] a, input logic [31:0] d);
    sb.push_back({a, d});
    jtag_addr = a;
    jtag_data = d;
    jtag_wen  = 1'b1;
    tick(3);
    jtag_wen  = 1'b0;
    tick(4);
  endtask

  initial begin
    rst = 1'b1; jtag_wen = 1'b0; jtag_addr = '0; jtag_data = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state and release window.
    tick(3);
    @(negedge clk);
    check("rst_cpu_rst",    48'(cpu_rst),    48'd1);
    check("rst_loading",    48'(loading),    48'd0);
    check("rst_load_done",  48'(load_done),  48'd0);
    check("rst_load_count", 48'(load_count), 48'd0);
    check("rst_mem_we",     48'(mem_we),     48'd0);
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick(1);
      @(negedge clk);
      if (i == 1 || i >= 15) begin
        check($sformatf("release_cpu_rst_%0d", i), 48'(cpu_rst), 48'(i < 16));
        check($sformatf("release_done_%0d", i), 48'(load_done), 48'(i == 16));
      end
    end

    // CPU store in IDLE goes straight through.
    tick(1);
    cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 32'h0000_1234;
    sb.push_back({16'h0040, 32'h0000_1234});
    @(negedge clk);
    check("idle_cpu_addr", 48'(mem_addr), 48'h40);
    check("idle_cpu_we",   48'(mem_we),   48'd1);
    tick(1);
    cpu_we = 1'b0;

    // Single load: strobe held high for 20 cycles.
    sb.push_back({16'h0010, 32'hDEAD_BEEF});
    jtag_addr = 16'h0010; jtag_data = 32'hDEAD_BEEF; jtag_wen = 1'b1;
    tick(3);
    @(negedge clk);
    check("load_entered",   48'(loading), 48'd1);
    check("load_cpu_rst",   48'(cpu_rst), 48'd1);
    check("load_no_we_yet", 48'(mem_we),  48'd0);
    tick(1);
    @(negedge clk);
    check("load_we_pulse",  48'(mem_we),     48'd1);
    check("load_count_1",   48'(load_count), 48'd1);
    tick(1);
    @(negedge clk);
    check("load_we_single", 48'(mem_we), 48'd0);
    tick(15);
    jtag_wen = 1'b0;
    tick(4);

    // Two more writes, then silence until timeout.
    jtag_write(16'h0011, 32'h1111_0001);
    check("load_count_2", 48'(load_count), 48'd2);
    jtag_write(16'h0012, 32'h1111_0002);
    check("load_count_3", 48'(load_count), 48'd3);
    // Last strobe rose 7 cycles ago; LOAD ends 1027 edges after that rise.
    tick(1019);
    @(negedge clk);
    check("timeout_still_loading", 48'(loading), 48'd1);
    tick(1);
    @(negedge clk);
    check("timeout_left_load", 48'(loading), 48'd0);
    check("timeout_cpu_rst",   48'(cpu_rst), 48'd1);
    tick(15);
    @(negedge clk);
    check("timeout_rel_cpu_rst", 48'(cpu_rst),   48'd1);
    tick(1);
    @(negedge clk);
    check("timeout_idle_cpu_rst", 48'(cpu_rst),    48'd0);
    check("timeout_done_pulse",   48'(load_done),  48'd1);
    check("timeout_count_kept",   48'(load_count), 48'd3);

    // Arbitration: CPU store in the same cycle the JTAG edge is detected.
    tick(2);
    sb.push_back({16'h0030, 32'h3030_3030});
    jtag_addr = 16'h0030; jtag_data = 32'h3030_3030; jtag_wen = 1'b1;
    tick(2);
    cpu_we = 1'b1; cpu_addr = 16'h0044; cpu_wdata = 32'h0000_CAFE;
    @(negedge clk);
    check("arb_cpu_blocked", 48'(mem_we),  48'd0);
    check("arb_still_idle",  48'(loading), 48'd0);
    tick(1);
    @(negedge clk);
    check("arb_cpu_ignored", 48'(mem_we), 48'd0);
    tick(1);
    cpu_we = 1'b0;
    @(negedge clk);
    check("arb_jtag_we",    48'(mem_we),     48'd1);
    check("arb_count",      48'(load_count), 48'd1);
    jtag_wen = 1'b0;

    // Re-entry from RELEASE cycle 5.
    begin
      bit left = 1'b0;
      for (int i = 0; i < 1100; i++) begin
        tick(1);
        if (loading === 1'b0) begin
          left = 1'b1;
          break;
        end
      end
      check("reentry_reached_release", 48'(left), 48'd1);
    end
    tick(2);
    sb.push_back({16'h0020, 32'h2020_2020});
    jtag_addr = 16'h0020; jtag_data = 32'h2020_2020; jtag_wen = 1'b1;
    tick(2);
    @(negedge clk);
    check("reentry_in_release", 48'(loading), 48'd0);
    check("reentry_cpu_rst",    48'(cpu_rst), 48'd1);
    tick(1);
    @(negedge clk);
    check("reentry_loading",    48'(loading),    48'd1);
    check("reentry_count_kept", 48'(load_count), 48'd1);
    tick(1);
    @(negedge clk);
    check("reentry_count_inc",  48'(load_count), 48'd2);
    check("reentry_no_done",    48'(load_done),  48'd0);
    jtag_wen = 1'b0;
    tick(4);

    // Reset with a captured write pending: the write must be dropped.
    jtag_addr = 16'h0077; jtag_data = 32'h7777_7777; jtag_wen = 1'b1;
    tick(3);
    rst = 1'b1; jtag_wen = 1'b0;
    tick(1);
    @(negedge clk);
    check("midrst_mem_we",  48'(mem_we),     48'd0);
    check("midrst_loading", 48'(loading),    48'd0);
    check("midrst_cpu_rst", 48'(cpu_rst),    48'd1);
    check("midrst_count",   48'(load_count), 48'd0);
    rst = 1'b0;
    tick(6);
    @(negedge clk);
    check("midrst_after_loading", 48'(loading), 48'd0);
    check("midrst_after_cpu_rst", 48'(cpu_rst), 48'd1);

    check("scoreboard_drained", 48'(sb.size()), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pb_load_ctrl

`default_nettype wire
